// File: rtl/pulse_identifier_multi_if.sv
// Bundle of sensor, engine and back-end signals around the multi-channel pulse identifier.
// The slave modport is the identifier itself; master is whatever drives it.
interface pulse_identifier_multi_if #(
    parameter int NUM_SENSORS = 4,
    parameter int DATA_W      = 17,
    parameter int TS_W        = 24
);
    logic [NUM_SENSORS-1:0]        data_available;
    logic [NUM_SENSORS*TS_W-1:0]   ts_data;
    logic [NUM_SENSORS*DATA_W-1:0] decoded_data;
    logic [NUM_SENSORS-1:0]        reset_bmc_decoder;

    logic                          poly_enable;
    logic [TS_W-1:0]               poly_ts_a;
    logic [TS_W-1:0]               poly_ts_b;
    logic [DATA_W-1:0]             poly_data_a;
    logic [DATA_W-1:0]             poly_data_b;
    logic                          poly_ready;
    logic [DATA_W-1:0]             poly_result;
    logic [DATA_W-1:0]             poly_iteration;

    logic                          off_enable;
    logic [DATA_W-1:0]             off_polynomial;
    logic [DATA_W-1:0]             off_data;
    logic                          off_ready;
    logic [DATA_W-1:0]             off_result;

    logic                          consume;
    logic [NUM_SENSORS*DATA_W-1:0] pulse_id;
    logic [NUM_SENSORS-1:0]        valid_mask;
    logic [DATA_W-1:0]             polynomial;
    logic                          ready;
    logic [7:0]                    error_count;

    modport slave (
        input  data_available, ts_data, decoded_data,
        input  poly_ready, poly_result, poly_iteration,
        input  off_ready, off_result, consume,
        output reset_bmc_decoder,
        output poly_enable, poly_ts_a, poly_ts_b, poly_data_a, poly_data_b,
        output off_enable, off_polynomial, off_data,
        output pulse_id, valid_mask, polynomial, ready, error_count
    );

    modport master (
        output data_available, ts_data, decoded_data,
        output poly_ready, poly_result, poly_iteration,
        output off_ready, off_result, consume,
        input  reset_bmc_decoder,
        input  poly_enable, poly_ts_a, poly_ts_b, poly_data_a, poly_data_b,
        input  off_enable, off_polynomial, off_data,
        input  pulse_id, valid_mask, polynomial, ready, error_count
    );
endinterface

// File: rtl/pulse_identifier_multi.sv
// Collects one LFSR word per sensor channel during a sweep, resolves polynomial, offset
// and per-channel iterations through the shared engines, and publishes per-channel pulse IDs.
module pulse_identifier_multi #(
    parameter int NUM_SENSORS  = 4,
    parameter int DATA_W       = 17,
    parameter int TS_W         = 24,
    parameter int WINDOW_TICKS = 100000
) (
    input logic                     clk_96MHz,
    input logic                     reset,
    pulse_identifier_multi_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_SENSORS);
    localparam int CNT_W = $clog2(NUM_SENSORS + 1);
    localparam int TMR_W = $clog2(WINDOW_TICKS);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(WINDOW_TICKS - 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_COLLECT, S_POLY, S_OFFSET, S_ITER, S_DONE, S_ERROR
    } state_t;

    state_t                 r_state;
    logic [NUM_SENSORS-1:0] r_captured;
    logic [NUM_SENSORS-1:0] r_reset_bmc;
    logic [CH_W-1:0]        r_order [NUM_SENSORS];
    logic [DATA_W-1:0]      r_iter [NUM_SENSORS];
    logic [DATA_W-1:0]      r_word [NUM_SENSORS];
    logic [TS_W-1:0]        r_ts [NUM_SENSORS];
    logic [DATA_W-1:0]      r_pulse_id [NUM_SENSORS];
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_iter_idx;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_armed;
    logic                   r_poly_enable;
    logic [TS_W-1:0]        r_poly_ts_a;
    logic [TS_W-1:0]        r_poly_ts_b;
    logic [DATA_W-1:0]      r_poly_data_a;
    logic [DATA_W-1:0]      r_poly_data_b;
    logic                   r_off_enable;
    logic [DATA_W-1:0]      r_off_polynomial;
    logic [DATA_W-1:0]      r_off_data;
    logic [DATA_W-1:0]      r_offset;
    logic [DATA_W-1:0]      r_polynomial;
    logic [NUM_SENSORS-1:0] r_valid_mask;
    logic                   r_ready;
    logic [7:0]             r_error_count;

    logic [DATA_W-1:0]      w_word_in [NUM_SENSORS];
    logic [TS_W-1:0]        w_ts_in [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] w_cand;
    logic [CH_W-1:0]        w_sel;
    logic                   w_hit;
    logic                   w_timeout;
    logic                   w_all_captured;
    logic                   w_capture;
    logic [CH_W-1:0]        w_first;
    logic [CH_W-1:0]        w_pair_b;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_lanes
        assign w_word_in[g]                   = bus.decoded_data[g*DATA_W +: DATA_W];
        assign w_ts_in[g]                     = bus.ts_data[g*TS_W +: TS_W];
        assign bus.pulse_id[g*DATA_W +: DATA_W] = r_pulse_id[g];
    end

    // A channel just released is masked for one cycle so a slow decoder cannot re-trigger it.
    assign w_cand = bus.data_available & ~r_captured & ~r_reset_bmc;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_hit = 1'b1;
                w_sel = CH_W'(i);
            end
        end
    end

    assign w_all_captured = &r_captured;
    assign w_timeout      = (r_count != '0) && (r_timer == LAST_TICK);
    assign w_capture      = (r_state == S_COLLECT) && w_hit && !w_all_captured && !w_timeout;
    assign w_first        = r_order[0];
    assign w_pair_b       = r_order[CH_W'(r_iter_idx)];

    // NOTE: word/timestamp storage has no reset; each entry is written on capture before any read.
    always_ff @(posedge clk_96MHz) begin
        if (w_capture) begin
            r_word[w_sel] <= w_word_in[w_sel];
            r_ts[w_sel]   <= w_ts_in[w_sel];
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset || r_state == S_CLEAR) begin
            r_state       <= reset ? S_CLEAR : S_IDLE;
            r_captured    <= '0;
            r_reset_bmc   <= '0;
            r_count       <= '0;
            r_iter_idx    <= '0;
            r_timer       <= '0;
            r_armed       <= 1'b0;
            r_poly_enable <= 1'b0;
            r_off_enable  <= 1'b0;
            r_offset      <= '0;
            r_polynomial  <= '0;
            r_valid_mask  <= '0;
            r_ready       <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_order[i]    <= '0;
                r_iter[i]     <= '0;
                r_pulse_id[i] <= '0;
            end
            r_poly_ts_a      <= '0;
            r_poly_ts_b      <= '0;
            r_poly_data_a    <= '0;
            r_poly_data_b    <= '0;
            r_off_polynomial <= '0;
            r_off_data       <= '0;
            if (reset) r_error_count <= '0;
        end else begin
            // NOTE: non-blocking default then override inside the case yields a one-cycle pulse.
            r_reset_bmc <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.data_available) r_state <= S_COLLECT;
                end

                S_COLLECT: begin
                    if (w_all_captured) begin
                        r_iter_idx <= CNT_W'(1);
                        r_state    <= S_POLY;
                    end else if (w_timeout) begin
                        r_iter_idx <= CNT_W'(1);
                        r_state    <= (r_count >= CNT_W'(2)) ? S_POLY : S_ERROR;
                    end else begin
                        if (r_count != '0) r_timer <= r_timer + TMR_W'(1);
                        if (w_capture) begin
                            r_captured[w_sel]        <= 1'b1;
                            r_reset_bmc[w_sel]       <= 1'b1;
                            r_order[CH_W'(r_count)]  <= w_sel;
                            r_count                  <= r_count + CNT_W'(1);
                        end
                    end
                end

                // POLY resolves the first pair; ITER walks the remaining captures against the first.
                S_POLY, S_ITER: begin
                    if (r_state == S_ITER && !r_poly_enable && r_iter_idx >= r_count) begin
                        for (int i = 0; i < NUM_SENSORS; i++)
                            r_pulse_id[i] <= r_captured[i] ? r_offset + r_iter[i] : '0;
                        r_valid_mask <= r_captured;
                        r_ready      <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (!r_poly_enable) begin
                        r_poly_enable <= 1'b1;
                        r_armed       <= 1'b0;
                        r_poly_ts_a   <= r_ts[w_first];
                        r_poly_data_a <= r_word[w_first];
                        r_poly_ts_b   <= r_ts[w_pair_b];
                        r_poly_data_b <= r_word[w_pair_b];
                    end else if (!r_armed) begin
                        if (!bus.poly_ready) r_armed <= 1'b1;
                    end else if (bus.poly_ready) begin
                        r_poly_enable      <= 1'b0;
                        r_iter[w_pair_b]   <= bus.poly_iteration;
                        r_iter_idx         <= r_iter_idx + CNT_W'(1);
                        if (r_state == S_POLY) begin
                            if (bus.poly_result == '0) begin
                                r_state <= S_ERROR;
                            end else begin
                                r_polynomial <= bus.poly_result;
                                r_state      <= S_OFFSET;
                            end
                        end else if (bus.poly_result != '0 && bus.poly_result != r_polynomial) begin
                            r_state <= S_ERROR;
                        end
                    end
                end

                S_OFFSET: begin
                    if (!r_off_enable) begin
                        r_off_enable     <= 1'b1;
                        r_armed          <= 1'b0;
                        r_off_polynomial <= r_polynomial;
                        r_off_data       <= r_word[w_first];
                    end else if (!r_armed) begin
                        if (!bus.off_ready) r_armed <= 1'b1;
                    end else if (bus.off_ready) begin
                        r_off_enable <= 1'b0;
                        if (bus.off_result == '0) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_offset <= bus.off_result;
                            r_state  <= S_ITER;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.consume) begin
                        r_ready <= 1'b0;
                        r_state <= S_CLEAR;
                    end
                end

                S_ERROR: begin
                    if (r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
                    r_state <= S_CLEAR;
                end

                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.reset_bmc_decoder = r_reset_bmc;
    assign bus.poly_enable       = r_poly_enable;
    assign bus.poly_ts_a         = r_poly_ts_a;
    assign bus.poly_ts_b         = r_poly_ts_b;
    assign bus.poly_data_a       = r_poly_data_a;
    assign bus.poly_data_b       = r_poly_data_b;
    assign bus.off_enable        = r_off_enable;
    assign bus.off_polynomial    = r_off_polynomial;
    assign bus.off_data          = r_off_data;
    assign bus.valid_mask        = r_valid_mask;
    assign bus.polynomial        = r_polynomial;
    assign bus.ready             = r_ready;
    assign bus.error_count       = r_error_count;
endmodule

// File: tb/tb_pulse_identifier_multi.sv
// Bench for pulse_identifier_multi: behavioural decoders and engines, directed vector table,
// a mid-sweep reset sequence and randomized sweeps checked against a sort-based reference model.
module tb_pulse_identifier_multi;
    localparam int NS = 4;
    localparam int DW = 17;
    localparam int TSW = 24;
    localparam int W = 100;

    logic clk_96MHz = 1'b0;
    logic reset;
    always #5 clk_96MHz = ~clk_96MHz;

    pulse_identifier_multi_if #(.NUM_SENSORS(NS), .DATA_W(DW), .TS_W(TSW)) bus ();

    pulse_identifier_multi #(
        .NUM_SENSORS(NS), .DATA_W(DW), .TS_W(TSW), .WINDOW_TICKS(W)
    ) dut (
        .clk_96MHz(clk_96MHz),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [NS-1:0]         chans;
        logic [NS-1:0][7:0]    arr;
        logic [DW-1:0]         poly;
        logic [DW-1:0]         offset;
        logic [NS-1:0][DW-1:0] itv;
        int                    fault;   // 0 none, 1 poly=0, 2 offset=0, 3 ITER poly differs
        bit                    exp_err;
        logic [NS-1:0][DW-1:0] exp_pid;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc, sweep_no, lat, pcnt, ocnt, preq, oreq, bad_pair, exp_err_cnt;
    logic [DW-1:0]  words [NS];
    logic [TSW-1:0] tss [NS];
    logic [DW-1:0]  resp_poly, resp_iter;
    vec_t cur;
    int pulse_log [$];
    int exp_order [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (sweep %0d)", name, act, exp, sweep_no);
        end
    endtask

    function automatic vec_t mk(input logic [NS-1:0] chans, input logic [NS*8-1:0] arr,
                                input logic [DW-1:0] poly, input logic [DW-1:0] offset,
                                input logic [NS*DW-1:0] itv, input int fault,
                                input bit err, input logic [NS*DW-1:0] pid);
        vec_t v;
        v.chans = chans; v.arr = arr; v.poly = poly; v.offset = offset;
        v.itv = itv; v.fault = fault; v.exp_err = err; v.exp_pid = pid;
        return v;
    endfunction

    // Capture order: by arrival cycle, ties broken by lower channel index.
    function automatic void compute_order(input vec_t v);
        exp_order.delete();
        for (int t = 0; t < 256; t++)
            for (int i = 0; i < NS; i++)
                if (v.chans[i] && int'(v.arr[i]) == t) exp_order.push_back(i);
    endfunction

    function automatic void model(inout vec_t v);
        int n;
        compute_order(v);
        n = exp_order.size();
        v.exp_err = (n < 2) || v.fault == 1 || v.fault == 2 || (v.fault == 3 && n >= 3);
        v.exp_pid = '0;
        if (!v.exp_err)
            foreach (exp_order[j])
                v.exp_pid[exp_order[j]] = (j == 0) ? v.offset : DW'(v.offset + v.itv[exp_order[j]]);
    endfunction

    function automatic int exp_poly_reqs(input vec_t v);
        int n = exp_order.size();
        if (n < 2) return 0;
        if (v.fault == 1 || v.fault == 2) return 1;
        if (v.fault == 3 && n >= 3) return 2;
        return n - 1;
    endfunction

    // One clock: behavioural decoders release on reset_bmc_decoder, engines answer requests.
    task automatic tick();
        int kb;
        int f;
        @(posedge clk_96MHz);
        #1;
        cyc++;
        f = exp_order.size() > 0 ? exp_order[0] : 0;
        for (int i = 0; i < NS; i++)
            if (bus.reset_bmc_decoder[i]) begin
                bus.data_available[i] = 1'b0;
                pulse_log.push_back(i);
            end
        if (bus.poly_enable) begin
            pcnt++;
            if (pcnt == 1) begin
                preq++;
                kb = -1;
                for (int i = 0; i < NS; i++) if (words[i] == bus.poly_data_b) kb = i;
                if (kb < 0 || bus.poly_ts_b != tss[kb] || bus.poly_data_a != words[f] ||
                    bus.poly_ts_a != tss[f]) bad_pair++;
                resp_iter = (kb < 0) ? '0 : cur.itv[kb];
                resp_poly = cur.poly;
                if (cur.fault == 1 && preq == 1) resp_poly = '0;
                if (cur.fault == 3 && preq == 2) resp_poly = cur.poly ^ 17'h00400;
            end
            if (pcnt == 2) bus.poly_ready = 1'b0;
            if (pcnt == lat) begin
                bus.poly_ready     = 1'b1;
                bus.poly_result    = resp_poly;
                bus.poly_iteration = resp_iter;
            end
        end else pcnt = 0;
        if (bus.off_enable) begin
            ocnt++;
            if (ocnt == 1) begin
                oreq++;
                if (bus.off_data != words[f] || bus.off_polynomial != cur.poly) bad_pair++;
            end
            if (ocnt == 2) bus.off_ready = 1'b0;
            if (ocnt == lat) begin
                bus.off_ready  = 1'b1;
                bus.off_result = (cur.fault == 2) ? '0 : cur.offset;
            end
        end else ocnt = 0;
        for (int i = 0; i < NS; i++)
            if (cur.chans[i] && int'(cur.arr[i]) == cyc) bus.data_available[i] = 1'b1;
    endtask

    task automatic start_sweep(input vec_t v);
        sweep_no++;
        cur = v;
        compute_order(v);
        for (int i = 0; i < NS; i++) begin
            words[i] = DW'(17'h00ABC + 17'h01111 * i + sweep_no * 3);
            tss[i]   = TSW'(750 + 250 * i + sweep_no);
            bus.decoded_data[i*DW +: DW] = words[i];
            bus.ts_data[i*TSW +: TSW]    = tss[i];
        end
        lat = $urandom_range(6, 3);
        preq = 0; oreq = 0; pcnt = 0; ocnt = 0; bad_pair = 0; cyc = 0;
        pulse_log.delete();
        for (int i = 0; i < NS; i++)
            if (v.chans[i] && v.arr[i] == 8'd0) bus.data_available[i] = 1'b1;
    endtask

    task automatic finish_sweep(input vec_t v);
        logic [7:0] err0 = bus.error_count;
        bit done = 0;
        int mism = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            tick();
            if (bus.ready || bus.error_count != err0) done = 1;
        end
        check("sweep_terminates", done, 1);
        if (v.exp_err) begin
            exp_err_cnt++;
            check("error_count", bus.error_count, exp_err_cnt);
            check("ready_on_error", bus.ready, 0);
            if (exp_order.size() < 2)
                check("timeout_cycle", cyc, W + 3 + int'(v.arr[exp_order[0]]));
            repeat (2) tick();
            check("mask_after_error", bus.valid_mask, 0);
            check("ready_after_error", bus.ready, 0);
        end else begin
            check("ready", bus.ready, 1);
            repeat (3) tick();
            check("ready_held", bus.ready, 1);
            check("valid_mask", bus.valid_mask, v.chans);
            check("polynomial", bus.polynomial, v.poly);
            for (int i = 0; i < NS; i++)
                check($sformatf("pulse_id%0d", i), bus.pulse_id[i*DW +: DW], v.exp_pid[i]);
            bus.consume = 1'b1;
            tick();
            bus.consume = 1'b0;
            check("ready_after_consume", bus.ready, 0);
            tick();
            check("mask_cleared", bus.valid_mask, 0);
        end
        check("pulse_count", pulse_log.size(), exp_order.size());
        foreach (pulse_log[j]) if (j >= exp_order.size() || pulse_log[j] != exp_order[j]) mism++;
        check("pulse_order", mism, 0);
        check("poly_requests", preq, exp_poly_reqs(v));
        check("off_requests", oreq, (exp_order.size() < 2 || v.fault == 1) ? 0 : 1);
        check("engine_operands", bad_pair, 0);
    endtask

    task automatic run_sweep(input vec_t v);
        start_sweep(v);
        finish_sweep(v);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        bit reached;
        int j;

        tbl[0] = mk(4'b1010, {8'd10, 8'd0, 8'd0, 8'd0}, 17'h1D258, 17'd500,
                    {17'd37, 17'd0, 17'd0, 17'd0}, 0, 0, {17'd537, 17'd0, 17'd500, 17'd0});
        tbl[1] = mk(4'b1111, '0, 17'h0F00D, 17'd1000,
                    {17'd200, 17'd9, 17'd5, 17'd0}, 0, 0, {17'd1200, 17'd1009, 17'd1005, 17'd1000});
        tbl[2] = mk(4'b0100, '0, 17'h1D258, 17'd500, '0, 0, 1, '0);
        tbl[3] = mk(4'b0011, {8'd0, 8'd0, 8'd5, 8'd0}, 17'h1D258, 17'd77, '0, 1, 1, '0);
        tbl[4] = mk(4'b1001, '0, 17'h1D258, 17'd77, '0, 2, 1, '0);
        tbl[5] = mk(4'b0101, {8'd0, 8'd5, 8'd0, 8'd0}, 17'h12345, 17'h1FFF0,
                    {17'd0, 17'h00020, 17'd0, 17'd0}, 0, 0, {17'd0, 17'h00010, 17'd0, 17'h1FFF0});
        tbl[6] = mk(4'b1110, '0, 17'h0BEEF, 17'd42, {17'd3, 17'd2, 17'd1, 17'd0}, 3, 1, '0);
        tbl[7] = mk(4'b0011, '0, 17'h0BEEF, 17'h00123, {17'd0, 17'd0, 17'h00045, 17'd0}, 3, 0,
                    {17'd0, 17'd0, 17'h00168, 17'h00123});

        reset = 1'b1;
        bus.data_available = '0; bus.ts_data = '0; bus.decoded_data = '0;
        bus.poly_ready = 1'b0; bus.poly_result = '0; bus.poly_iteration = '0;
        bus.off_ready = 1'b0; bus.off_result = '0; bus.consume = 1'b0;
        sweep_no = 0; exp_err_cnt = 0; cyc = 0;
        cur = tbl[0];
        repeat (3) tick();
        check("rst_ready", bus.ready, 0);
        check("rst_valid_mask", bus.valid_mask, 0);
        check("rst_poly_enable", bus.poly_enable, 0);
        check("rst_off_enable", bus.off_enable, 0);
        check("rst_error_count", bus.error_count, 0);
        check("rst_polynomial", bus.polynomial, 0);
        check("rst_reset_bmc", bus.reset_bmc_decoder, 0);
        check("rst_pulse_id_nonzero", |bus.pulse_id, 0);
        reset = 1'b0;
        repeat (2) tick();

        for (int t = 0; t < 8; t++) run_sweep(tbl[t]);

        // Reset while the ITER phase has a pair request outstanding.
        v = tbl[1];
        compute_order(v);
        start_sweep(v);
        reached = 0;
        for (int n = 0; n < 500 && !reached; n++) begin
            tick();
            if (preq == 2) reached = 1;
        end
        check("iter_reached", reached, 1);
        reset = 1'b1;
        tick();
        check("midreset_poly_enable", bus.poly_enable, 0);
        check("midreset_ready", bus.ready, 0);
        check("midreset_error_count", bus.error_count, 0);
        reset = 1'b0;
        bus.data_available = '0;
        exp_err_cnt = 0;
        repeat (2) tick();
        run_sweep(tbl[1]);

        for (int r = 0; r < 24; r++) begin
            int f;
            v.chans  = NS'($urandom_range((1 << NS) - 1, 1));
            v.poly   = DW'($urandom_range((1 << DW) - 1, 1));
            v.offset = DW'($urandom_range((1 << DW) - 1, 1));
            j = 0;
            for (int i = 0; i < NS; i++) begin
                v.itv[i] = DW'($urandom);
                if (v.chans[i] && $urandom_range(1, 0) == 0) begin
                    v.arr[i] = 8'(5 + 3 * j);
                    j++;
                end else v.arr[i] = 8'd0;
            end
            f = $urandom_range(9, 0);
            v.fault = (f < 6) ? 0 : (f == 6) ? 1 : (f == 7) ? 2 : 3;
            model(v);
            run_sweep(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
